regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 146 ++++++++++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp : multi-port register file (2 write ports, NRD read ports) with a
//              self-clearing walk after reset or on a runtime clear request.
//
// Parameters
//   XLEN  data width in bits
//   NREG  number of registers (power of two, >= 4)
//   NRD   number of read ports (1..8)
//   AW    derived address width, $clog2(NREG)
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset (restarts the clear walk)
//   clr              runtime re-initialise request, honoured only in RUN
//   ready            registered, high while the file is in RUN
//   we0/wa0/wd0      write port 0: enable, address, data
//   we1/wa1/wd1      write port 1: enable, address, data (wins on collision)
//   ra               packed read addresses, port k at [k*AW +: AW]
//   rd               packed read data, port k at [k*XLEN +: XLEN]
//
// Build option
//   REGFILE_MP_BYPASS_EN  when defined, a read of an address being written in
//                         the same cycle returns the write data (port 1 over
//                         port 0); otherwise it returns the old contents.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                ready,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_r;
    logic [AW-1:0]       idx_r;
    logic                ready_r;
    logic [XLEN-1:0]     regs_r [NREG];

    logic                run_wr_s;
    logic                wr0_s;
    logic                wr1_s;
    logic [NRD*XLEN-1:0] rd_s;
    logic [AW-1:0]       ra_k_s;

    // Qualified write strobes: only in RUN, never on a reset or clear edge, never to address 0
    always_comb begin
        run_wr_s = (state_r == ST_RUN) && !rst && !clr;
        wr0_s    = run_wr_s && we0 && (wa0 != '0);
        wr1_s    = run_wr_s && we1 && (wa1 != '0);
    end

    // Control FSM: clear walk over every index, then RUN until clr or rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            idx_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (idx_r == AW'(NREG - 1)) begin
                        state_r <= ST_RUN;
                        idx_r   <= '0;
                        ready_r <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + AW'(1);
                        ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state_r <= ST_CLEAR;
                        idx_r   <= '0;
                        ready_r <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    idx_r   <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: clear walk in CLEAR, otherwise the two write ports (port 1 assigned last, so it wins)
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_CLEAR)) begin
            regs_r[idx_r] <= '0;
        end else begin
            if (wr0_s) begin
                regs_r[wa0] <= wd0;
            end
            if (wr1_s) begin
                regs_r[wa1] <= wd1;
            end
        end
    end

    // Combinational read lanes; address 0 and the CLEAR state always read zero
    always_comb begin
        rd_s   = '0;
        ra_k_s = '0;
        for (int k = 0; k < NRD; k++) begin
            ra_k_s = ra[k*AW +: AW];
            if ((state_r == ST_RUN) && (ra_k_s != '0)) begin
`ifdef REGFILE_MP_BYPASS_EN
                if (wr1_s && (wa1 == ra_k_s)) begin
                    rd_s[k*XLEN +: XLEN] = wd1;
                end else if (wr0_s && (wa0 == ra_k_s)) begin
                    rd_s[k*XLEN +: XLEN] = wd0;
                end else begin
                    rd_s[k*XLEN +: XLEN] = regs_r[ra_k_s];
                end
`else
                rd_s[k*XLEN +: XLEN] = regs_r[ra_k_s];
`endif
            end else begin
                rd_s[k*XLEN +: XLEN] = '0;
            end
        end
    end

    assign ready = ready_r;
    assign rd    = rd_s;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp : directed self-checking bench for regfile_mp with the default
//                 parameters (XLEN=32, NREG=32, NRD=2).
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ready;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [9:0]  ra;
    logic [63:0] rd;

    int n_chk;
    int n_pass;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .ready (ready),
        .we0   (we0),
        .wa0   (wa0),
        .wd0   (wd0),
        .we1   (we1),
        .wa1   (wa1),
        .wd1   (wd1),
        .ra    (ra),
        .rd    (rd)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One rising edge, then step off the edge before anything is sampled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        we0 = 1'b1; wa0 = a; wd0 = d;
        tick();
        we0 = 1'b0;
    endtask

    logic [31:0] bypass_exp;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1; clr = 1'b0;
        we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
        we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
        ra  = 10'd0;
        #2;

        // Reset and initial clear walk
        tick();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            ra = {5'(i), 5'(31 - i)};
            tick();
            if (i < 32) begin
                chk("init_ready_low", {31'd0, ready}, 32'd0);
                chk("init_rd0", rd[31:0], 32'd0);
                chk("init_rd1", rd[63:32], 32'd0);
            end else begin
                chk("init_ready_high", {31'd0, ready}, 32'd1);
            end
        end

        // Basic write, 1-cycle latency, address 0 discards writes
        set_ra(5'd5, 5'd0);
        wr0(5'd5, 32'hDEADBEEF);
        set_ra(5'd5, 5'd0);
        chk("basic_rd5", rd[31:0], 32'hDEADBEEF);
        wr0(5'd0, 32'h00001234);
        set_ra(5'd0, 5'd5);
        chk("zero_rd0", rd[31:0], 32'd0);
        chk("basic_rd5_lane1", rd[63:32], 32'hDEADBEEF);

        // Same-address collision: port 1 wins
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        set_ra(5'd7, 5'd7);
        chk("collide_rd7", rd[31:0], 32'h22);
        // Distinct addresses: both commit
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h22;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        set_ra(5'd7, 5'd8);
        chk("dual_rd7", rd[31:0], 32'h11);
        chk("dual_rd8", rd[63:32], 32'h22);

        // Same-cycle read of a written address
        wr0(5'd3, 32'hA);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hB;
        set_ra(5'd3, 5'd4);
`ifdef REGFILE_MP_BYPASS_EN
        bypass_exp = 32'hB;
`else
        bypass_exp = 32'hA;
`endif
        chk("bypass_same_cycle", rd[31:0], bypass_exp);
        tick();
        we0 = 1'b0;
        set_ra(5'd3, 5'd4);
        chk("bypass_next_cycle", rd[31:0], 32'hB);

        // Fill 1..31, then runtime clear
        for (int i = 1; i < 32; i++) begin
            wr0(5'(i), 32'h1000_0000 + 32'(i));
        end
        set_ra(5'd31, 5'd1);
        chk("fill_rd31", rd[31:0], 32'h1000_001F);
        chk("fill_rd1", rd[63:32], 32'h1000_0001);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ready_drop", {31'd0, ready}, 32'd0);
        set_ra(5'd31, 5'd2);
        chk("clr_rd_gated", rd[31:0], 32'd0);
        for (int k = 1; k <= 32; k++) begin
            // Address 2 is already cleared by edge 10; a leaked write would stick
            if (k == 10) begin
                we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hFFFF;
                we1 = 1'b1; wa1 = 5'd1; wd1 = 32'hEEEE;
            end else begin
                we0 = 1'b0; we1 = 1'b0;
            end
            tick();
            if (k == 31) begin
                chk("clr_ready_k31", {31'd0, ready}, 32'd0);
            end else if (k == 32) begin
                chk("clr_ready_k32", {31'd0, ready}, 32'd1);
            end
        end
        we0 = 1'b0; we1 = 1'b0;
        for (int a = 0; a < 32; a += 2) begin
            set_ra(5'(a), 5'(a + 1));
            chk($sformatf("clr_rd%0d", a), rd[31:0], 32'd0);
            chk($sformatf("clr_rd%0d", a + 1), rd[63:32], 32'd0);
        end

        // Reset in the middle of a clear walk restarts it
        wr0(5'd9, 32'h99);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("midclr_rst_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 22) begin
                chk("midclr_ready_i22", {31'd0, ready}, 32'd0);
            end else if (i == 31) begin
                chk("midclr_ready_i31", {31'd0, ready}, 32'd0);
            end else if (i == 32) begin
                chk("midclr_ready_i32", {31'd0, ready}, 32'd1);
            end
        end
        set_ra(5'd9, 5'd5);
        chk("midclr_rd9", rd[31:0], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
